dmem_be: RTL and testbench
==========================

# dmem_be

Parametrised, byte-addressable data memory for the single-cycle MIPS datapath, replacing the fixed 64-word, word-only data memory. It adds the following:
- byte, halfword and word stores with byte-lane writes;
- signed and unsigned sub-word loads;
- misalignment and out-of-range error flags;
- a post-reset clear sequencer that zeroes the array one word per cycle and reports `busy`.

Write and read timing relative to the PC is unchanged: reads register on the rising edge, writes commit on the falling edge.

## Interface
- `DEPTH`, 64: number of 32-bit words; power of two, 4..4096.
- `BASE`, 32'h0000_0000: byte address of word 0; must be word-aligned.
- `clk`, in, 1: single clock. Reads, flags and FSM act on the rising edge; array writes act on the falling edge.
- `rstn`, in, 1: reset, synchronous, active-low, sampled on the `clk` rising edge.
- `we`, in, 1: store request.
- `size`, in, 2: access size. 00 = byte, 01 = half, 10 = word, 11 = reserved.
- `sext`, in, 1: loads only. 1 = sign-extend, 0 = zero-extend.
- `addr`, in, 32: byte address.
- `din`, in, 32: store data. The byte/half store uses `din[7:0]` / `din[15:0]`.
- `dout`, out, 32: registered load data.
- `busy`, out, 1: clear sequence in progress.
- `misalign`, out, 1: registered; last access was misaligned or used a reserved size.
- `oor`, out, 1: registered; last access fell outside `BASE`..`BASE+4*DEPTH-1`.

## Operation
- **Indexing:**
  - `off = addr - BASE`; word index = `off[IW+1:2]`, where `IW = log2(DEPTH)`.
  - Byte lane = `off[1:0]`, little-endian: lane 0 = bits 7:0.
- **Range:** the access is out of range when `addr < BASE` or `off >= 4*DEPTH`. This is an unsigned compare on 32 bits.
- **Alignment:** an access is misaligned when any of these holds:
  - half with `addr[0]=1`;
  - word with `addr[1:0]!=0`;
  - `size=11`.
- **Stores:**
  - Lane mask: byte = 1 lane; half = lanes {0,1} or {2,3}; word = all lanes.
  - Data is replicated into the selected lanes; unselected lanes keep their contents.
  - A store is suppressed when `busy`, misaligned, or out of range.
- **Loads** (`we=0`, not `busy`):
  - Select the byte or half at the lane, then extend it per `sext`; a word load ignores `sext`.
  - An erroneous load returns `dout=0`.
- **Stores and `dout`:** during a store `dout` holds its previous value. The flags still update.
- **FSM states:**
  - CLEAR: entered when `rstn=0`; `ptr` ← 0.
  - In CLEAR, each falling edge writes 0 to `mem[ptr]`, and each rising edge increments `ptr`.
  - At the rising edge where `ptr==DEPTH-1` (after that word is cleared), go to READY.
  - READY: normal operation, held until the next reset.
- **While `busy`:** `dout`, `misalign` and `oor` hold at 0, and all requests are ignored. The CPU must stall the PC while `busy=1`.

## Timing
- **Reset:** a rising edge with `rstn=0` forces, on that edge:
  - `dout=0`, `misalign=0`, `oor=0`, `busy=1`, `ptr=0`.
- **Reset mid-clear or mid-operation:** the clear restarts from word 0, and any in-flight store on the following falling edge is replaced by a clear write.
- **Clear duration:** `busy` stays high for exactly `DEPTH` rising edges after `rstn` returns high. The first access is accepted on the edge after `busy` falls.
- **Load latency:** the address is presented in cycle N and `dout` is valid after the rising edge mid-cycle N, i.e. a half-cycle. The flags follow the same timing.
- **Store commit:** on the falling edge of the same cycle, using `we`/`addr`/`din`/`size` held stable for the whole cycle.
- **Store then load, same word:**
  - A load in the same cycle as the store is impossible (`we=1` suppresses the `dout` update).
  - A load in the next cycle returns the new data.
- **Lane independence:** back-to-back byte stores to different lanes of one word in consecutive cycles both persist.
- **Wrap-around:** there is no address wrap. Addresses at or beyond `BASE+4*DEPTH` flag `oor` and never alias.

## Test plan
- **Reset and clear:**
  - Stimulus: preload garbage, pulse `rstn` low for 1 cycle, `DEPTH=64`.
  - Response: `busy=1` for 64 rising edges; every word reads 0 afterward; outputs are 0 during `busy`.
- **Byte lanes:**
  - Stimulus: SW 0x11223344 to 0x10, then SB 0xAA to 0x12, then LW 0x10.
  - Response: `dout=0x11AA3344`.
- **Load extension:**
  - Stimulus: word 0x10 = 0x8081F0FF; LB at 0x10 with `sext=1`, LBU at 0x10, LH at 0x12 with `sext=1`, LHU at 0x12.
  - Response, in order: 0xFFFFFFFF, 0x000000FF, 0xFFFF8081, 0x00008081.
- **Misalignment:**
  - Stimulus: SW to 0x12, SH to 0x11, and `size=11`.
  - Response: `misalign=1` each time and memory unchanged; a subsequent aligned load gives `misalign=0`.
- **Range:**
  - Stimulus: `BASE=0x1000`, `DEPTH=16`; LW 0x0FFC, LW 0x1040, LW 0x103C.
  - Response: `oor=1` with `dout=0` for the first two; `oor=0` for the third.
- **Reset mid-clear:**
  - Stimulus: assert `rstn` low at clear word 30.
  - Response: `ptr` restarts at 0 and `busy` lasts a full `DEPTH` edges after release.

Source files
------------

// File: rtl/dmem_be.sv
// Byte-addressable data memory for the single-cycle MIPS datapath.
// Loads and flags register on the rising edge; array writes land on the
// falling edge. After reset a sequencer zeroes the array one word per cycle
// while busy is high.
module dmem_be #(
    parameter int          DEPTH = 64,
    parameter logic [31:0] BASE  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sext,
    input  logic [31:0] addr,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        busy,
    output logic        misalign,
    output logic        oor
);
    localparam int          IW   = $clog2(DEPTH);
    localparam logic [31:0] SPAN = 32'(4 * DEPTH);

    typedef enum logic {CLEAR, READY} state_t;

    state_t          state_reg;
    logic [IW-1:0]   ptr_reg;
    logic [31:0]     mem [DEPTH];

    // Store accepted at the rising edge, committed on the following falling edge
    logic            wr_en_reg;
    logic [IW-1:0]   wr_idx_reg;
    logic [3:0]      wr_be_reg;
    logic [31:0]     wr_data_reg;

    logic [31:0]     off;
    logic [IW-1:0]   widx;
    logic [1:0]      lane;
    logic            mis_c;
    logic            oor_c;
    logic            err_c;
    logic [31:0]     rword;
    logic [31:0]     load_c;
    logic [3:0]      be_c;
    logic [31:0]     wdata_c;
    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;

    assign off   = addr - BASE;
    assign widx  = off[IW+1:2];
    assign lane  = off[1:0];
    assign oor_c = (addr < BASE) || (off >= SPAN);
    assign err_c = mis_c || oor_c;
    assign busy  = (state_reg == CLEAR);

    // Alignment check; the reserved size always counts as misaligned
    always_comb begin
        mis_c = 1'b0;
        case (size)
            2'b00:   mis_c = 1'b0;
            2'b01:   mis_c = addr[0];
            2'b10:   mis_c = (addr[1:0] != 2'b00);
            default: mis_c = 1'b1;
        endcase
    end

    // Load path: pick the lane(s) out of the addressed word and extend
    always_comb begin
        rword    = mem[widx];
        byte_sel = rword[{lane, 3'b000} +: 8];
        half_sel = lane[1] ? rword[31:16] : rword[15:0];
        case (size)
            2'b00:   load_c = {{24{sext & byte_sel[7]}}, byte_sel};
            2'b01:   load_c = {{16{sext & half_sel[15]}}, half_sel};
            default: load_c = rword;
        endcase
    end

    // Store path: lane enables plus store data replicated into every lane
    always_comb begin
        case (size)
            2'b00: begin
                be_c    = 4'b0001 << lane;
                wdata_c = {4{din[7:0]}};
            end
            2'b01: begin
                be_c    = lane[1] ? 4'b1100 : 4'b0011;
                wdata_c = {2{din[15:0]}};
            end
            default: begin
                be_c    = 4'b1111;
                wdata_c = din;
            end
        endcase
    end

    // Clear sequencer, registered load data, error flags and store capture
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg   <= CLEAR;
            ptr_reg     <= '0;
            dout        <= '0;
            misalign    <= 1'b0;
            oor         <= 1'b0;
            wr_en_reg   <= 1'b0;
            wr_idx_reg  <= '0;
            wr_be_reg   <= '0;
            wr_data_reg <= '0;
        end else if (state_reg == CLEAR) begin
            dout      <= '0;
            misalign  <= 1'b0;
            oor       <= 1'b0;
            wr_en_reg <= 1'b0;
            ptr_reg   <= ptr_reg + 1'b1;
            if (ptr_reg == IW'(DEPTH - 1))
                state_reg <= READY;
        end else begin
            misalign    <= mis_c;
            oor         <= oor_c;
            wr_en_reg   <= we && !err_c;
            wr_idx_reg  <= widx;
            wr_be_reg   <= be_c;
            wr_data_reg <= wdata_c;
            if (!we)
                dout <= err_c ? 32'h0 : load_c;
        end
    end

    // Falling-edge array write: a clear word while busy, otherwise the accepted store
    always_ff @(negedge clk) begin
        if (state_reg == CLEAR) begin
            mem[ptr_reg] <= '0;
        end else if (wr_en_reg) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be_reg[i])
                    mem[wr_idx_reg][8*i +: 8] <= wr_data_reg[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_be.sv
// Randomised and directed checks of dmem_be against a byte-array reference
// model. The driver pushes the expected response of every cycle into a queue;
// the monitor pops it after each rising edge and compares.
module tb_dmem_be;
    localparam int          DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int          NBYTE = 4 * DEPTH;

    logic        clk;
    logic        rstn;
    logic        we;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] din;
    logic [31:0] dout;
    logic        busy;
    logic        misalign;
    logic        oor;

    dmem_be #(.DEPTH(DEPTH), .BASE(BASE)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .we       (we),
        .size     (size),
        .sext     (sext),
        .addr     (addr),
        .din      (din),
        .dout     (dout),
        .busy     (busy),
        .misalign (misalign),
        .oor      (oor)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] dout;
        logic        mis;
        logic        oor;
        logic        busy;
        string       name;
    } exp_t;

    exp_t sbq[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference model: the memory as a flat little-endian byte array
    logic [7:0]  mb [NBYTE];
    int          busy_left = 0;
    logic [31:0] m_dout    = 32'h0;

    function automatic logic [31:0] model_load(input int o, input logic [1:0] sz, input logic sx);
        logic [7:0]  b;
        logic [15:0] h;
        case (sz)
            2'b00: begin
                b = mb[o];
                return sx ? {{24{b[7]}}, b} : {24'h0, b};
            end
            2'b01: begin
                h = {mb[o+1], mb[o]};
                return sx ? {{16{h[15]}}, h} : {16'h0, h};
            end
            default: return {mb[o+3], mb[o+2], mb[o+1], mb[o]};
        endcase
    endfunction

    // Drive one cycle of inputs and queue what the next rising edge must produce
    task automatic step(input logic r, input logic w, input logic [1:0] sz, input logic sx,
                        input logic [31:0] a, input logic [31:0] d, input string nm);
        exp_t e;
        logic m, o_r;
        int   o;
        @(negedge clk);
        #1;
        rstn = r; we = w; size = sz; sext = sx; addr = a; din = d;
        e.name = nm;
        if (!r) begin
            busy_left = DEPTH;
            for (int i = 0; i < NBYTE; i++) mb[i] = 8'h00;
            m_dout = 32'h0;
            e.dout = 32'h0; e.mis = 1'b0; e.oor = 1'b0; e.busy = 1'b1;
        end else if (busy_left > 0) begin
            busy_left--;
            e.dout = 32'h0; e.mis = 1'b0; e.oor = 1'b0; e.busy = (busy_left > 0);
        end else begin
            m   = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
            o_r = (a < BASE) || ((a - BASE) >= 32'(NBYTE));
            o   = o_r ? 0 : int'(a - BASE);
            if (w) begin
                if (!m && !o_r) begin
                    mb[o] = d[7:0];
                    if (sz != 2'b00) mb[o+1] = d[15:8];
                    if (sz == 2'b10) begin
                        mb[o+2] = d[23:16];
                        mb[o+3] = d[31:24];
                    end
                end
            end else begin
                m_dout = (m || o_r) ? 32'h0 : model_load(o, sz, sx);
            end
            e.dout = m_dout; e.mis = m; e.oor = o_r; e.busy = 1'b0;
        end
        sbq.push_back(e);
    endtask

    // Monitor: compare every rising-edge result against the queued expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                vectors++;
                if ({dout, misalign, oor, busy} !== {e.dout, e.mis, e.oor, e.busy}) begin
                    miscompares++;
                    $display("FAIL %s: got dout=%h mis=%b oor=%b busy=%b, want dout=%h mis=%b oor=%b busy=%b",
                             e.name, dout, misalign, oor, busy, e.dout, e.mis, e.oor, e.busy);
                end else begin
                    $display("ok   %s: addr=%h dout=%h mis=%b oor=%b busy=%b",
                             e.name, addr, dout, misalign, oor, busy);
                end
            end
        end
    end

    // Hard time limit so the run can never hang
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Random requests while the clear runs; all must be ignored
    task automatic busy_cycles(input int n, input string nm);
        for (int i = 0; i < n; i++)
            step(1'b1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)), 1'b0,
                 BASE + 32'($urandom_range(0, NBYTE - 1) & ~3), $urandom, nm);
    endtask

    task automatic read_all_zero(input string nm);
        for (int i = 0; i < DEPTH; i++)
            step(1'b1, 1'b0, 2'b10, 1'b0, BASE + 32'(4 * i), 32'h0, nm);
    endtask

    initial begin
        rstn = 1'b0; we = 1'b0; size = 2'b10; sext = 1'b0; addr = BASE; din = 32'h0;

        // Bring-up, then fill the array with garbage
        step(1'b0, 1'b0, 2'b10, 1'b0, BASE, 32'h0, "reset");
        busy_cycles(DEPTH, "clear0");
        for (int i = 0; i < DEPTH; i++)
            step(1'b1, 1'b1, 2'b10, 1'b0, BASE + 32'(4 * i), $urandom | 32'h1, "preload");
        step(1'b1, 1'b0, 2'b10, 1'b0, BASE + 32'h8, 32'h0, "preload_rd");

        // One-cycle reset pulse: exactly DEPTH busy edges, then all words zero
        step(1'b0, 1'b1, 2'b10, 1'b0, BASE, 32'hDEAD_BEEF, "reset_pulse");
        busy_cycles(DEPTH, "clear1");
        read_all_zero("cleared");

        // Byte lanes
        step(1'b1, 1'b1, 2'b10, 1'b0, BASE + 32'h10, 32'h1122_3344, "sw");
        step(1'b1, 1'b1, 2'b00, 1'b0, BASE + 32'h12, 32'h0000_00AA, "sb");
        step(1'b1, 1'b0, 2'b10, 1'b0, BASE + 32'h10, 32'h0, "lw_lanes");

        // Load extension
        step(1'b1, 1'b1, 2'b10, 1'b0, BASE + 32'h10, 32'h8081_F0FF, "sw_ext");
        step(1'b1, 1'b0, 2'b00, 1'b1, BASE + 32'h10, 32'h0, "lb");
        step(1'b1, 1'b0, 2'b00, 1'b0, BASE + 32'h10, 32'h0, "lbu");
        step(1'b1, 1'b0, 2'b01, 1'b1, BASE + 32'h12, 32'h0, "lh");
        step(1'b1, 1'b0, 2'b01, 1'b0, BASE + 32'h12, 32'h0, "lhu");

        // Misalignment: stores suppressed, then an aligned load sees old data
        step(1'b1, 1'b1, 2'b10, 1'b0, BASE + 32'h12, 32'h5555_5555, "sw_mis");
        step(1'b1, 1'b1, 2'b01, 1'b0, BASE + 32'h11, 32'h6666_6666, "sh_mis");
        step(1'b1, 1'b1, 2'b11, 1'b0, BASE + 32'h10, 32'h7777_7777, "rsv_st");
        step(1'b1, 1'b0, 2'b11, 1'b0, BASE + 32'h10, 32'h0, "rsv_ld");
        step(1'b1, 1'b0, 2'b10, 1'b0, BASE + 32'h10, 32'h0, "lw_after_mis");

        // Range boundaries
        step(1'b1, 1'b0, 2'b10, 1'b0, BASE - 32'h4, 32'h0, "lw_below");
        step(1'b1, 1'b0, 2'b10, 1'b0, BASE + 32'(NBYTE), 32'h0, "lw_above");
        step(1'b1, 1'b0, 2'b10, 1'b0, BASE + 32'(NBYTE - 4), 32'h0, "lw_top");
        step(1'b1, 1'b1, 2'b10, 1'b0, BASE + 32'(NBYTE), 32'hCAFE_F00D, "sw_above");
        step(1'b1, 1'b0, 2'b10, 1'b0, BASE, 32'h0, "lw_word0");

        // Randomised traffic around and beyond the mapped window
        for (int i = 0; i < 300; i++)
            step(1'b1, 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2)),
                 1'($urandom_range(0, 1)),
                 BASE - 32'h8 + 32'($urandom_range(0, NBYTE + 15)),
                 $urandom, "rand");

        // Reset in the middle of a clear restarts the full sequence
        step(1'b0, 1'b0, 2'b10, 1'b0, BASE, 32'h0, "reset_a");
        busy_cycles(10, "clear_part");
        step(1'b0, 1'b1, 2'b10, 1'b0, BASE, 32'h1234_5678, "reset_mid");
        busy_cycles(DEPTH, "clear2");
        read_all_zero("cleared2");

        @(negedge clk);
        @(negedge clk);
        if (sbq.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
